sine_pwm_sequencer: RTL

//  Sequences the PWM sine datapath: period counter, duty comparator and sine-duty lookup.

---
 rtl/sine_pwm_sequencer_pkg.sv | 15 +
 rtl/sine_quarter_lut.sv | 57 +++++
 rtl/sine_pwm_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sine_pwm_sequencer_pkg.sv
// Shared definitions for the sine PWM sequencer: FSM encoding and LUT timing.
package sine_pwm_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Address register plus data register inside the sine LUT.
    localparam int LUT_LATENCY  = 2;
    // PRIME issues the fetch, waits out the LUT latency, then loads width.
    localparam int PRIME_CYCLES = LUT_LATENCY + 1;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM expanded to a full wave by mirroring and negating.
// Output = round(PERIOD_MAX/2 * (1 + sin(2*pi*addr/2^LUT_AW))).
// Address and data are both registered, giving a 2-cycle read latency.
module sine_quarter_lut #(
    parameter int PERIOD_MAX = 1000,
    parameter int LUT_AW     = 8,
    localparam int DW        = $clog2(PERIOD_MAX + 1)
) (
    input  logic              clk,
    input  logic              addr_en,
    input  logic [LUT_AW-1:0] addr,
    output logic [DW-1:0]     data
);
    localparam int  IW   = LUT_AW - 2;
    localparam int  QN   = 2 ** IW;
    // Midscale; an odd PERIOD_MAX biases the waveform down by half a count.
    localparam int  HALF = PERIOD_MAX / 2;
    localparam real PI   = 3.14159265358979323846;

    logic [DW-1:0]     rom [QN];
    logic [LUT_AW-1:0] addr_reg;
    logic [DW-1:0]     data_reg;
    logic [1:0]        quad;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     rom_idx;
    logic              peak;
    logic [DW-1:0]     amp;
    logic [DW-1:0]     data_next;

    // First quadrant amplitudes, evaluated at elaboration time.
    for (genvar gi = 0; gi < QN; gi++) begin : g_rom
        localparam int AMP = $rtoi(real'(HALF) * $sin(2.0 * PI * real'(gi) / real'(4 * QN)) + 0.5);
        assign rom[gi] = DW'(AMP);
    end

    // Quadrant decode: odd quadrants read the table backwards, upper half negates.
    // The mirrored index for offset 0 is the quarter-wave peak, which lies one past the table.
    always_comb begin
        quad      = addr_reg[LUT_AW-1 -: 2];
        idx       = addr_reg[IW-1:0];
        peak      = quad[0] && (idx == '0);
        rom_idx   = quad[0] ? -idx : idx;
        amp       = peak ? DW'(HALF) : rom[rom_idx];
        data_next = quad[1] ? (DW'(HALF) - amp) : (DW'(HALF) + amp);
    end

    // Registered address then registered data; address holds between fetches.
    always_ff @(posedge clk) begin
        if (addr_en) begin
            addr_reg <= addr;
        end
        data_reg <= data_next;
    end

    assign data = data_reg;

endmodule

// File: rtl/sine_pwm_sequencer.sv
// PWM sine sequencer: period counter, duty comparator, phase accumulator and
// a 1-deep config shadow. New widths only land on period boundaries.
module sine_pwm_sequencer
    import sine_pwm_sequencer_pkg::*;
#(
    parameter int PERIOD_MAX = 1000,
    parameter int PHASE_BITS = 16,
    parameter int LUT_AW     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_enable,
    input  logic [PHASE_BITS-1:0] cfg_step,
    output logic [31:0]           width,
    output logic                  tick,
    output logic                  phase_wrap,
    output logic                  pwm_out,
    output logic                  busy
);
    localparam int CW  = $clog2(PERIOD_MAX);
    localparam int DW  = $clog2(PERIOD_MAX + 1);
    localparam int PCW = $clog2(PRIME_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST    = CW'(PERIOD_MAX - 1);
    localparam logic [CW-1:0]  CNT_PENDING = CW'(LUT_LATENCY);
    localparam logic [PCW-1:0] PRIME_LAST  = PCW'(PRIME_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [PCW-1:0]        prime_cnt_reg, prime_cnt_next;
    logic [PHASE_BITS-1:0] phase_reg, phase_next;
    logic [PHASE_BITS-1:0] step_reg, step_next;
    logic [DW-1:0]         width_reg, width_next;
    logic [DW-1:0]         width_pending_reg;
    logic                  pwm_out_reg;
    logic                  shadow_full_reg;
    logic                  shadow_enable_reg;
    logic [PHASE_BITS-1:0] shadow_step_reg;
    logic                  shadow_consume;
    logic                  cfg_xfer;
    logic                  last_cnt;
    logic                  tick_now;
    logic                  phase_carry;
    logic [PHASE_BITS-1:0] phase_sum;
    logic                  lut_addr_en;
    logic [LUT_AW-1:0]     lut_addr;
    logic [DW-1:0]         lut_data;

    assign cfg_xfer = cfg_valid && !shadow_full_reg;
    assign last_cnt = (cnt_reg == CNT_LAST);
    assign tick_now = (state_reg == RUN) && last_cnt;
    assign {phase_carry, phase_sum} = {1'b0, phase_reg} + {1'b0, step_reg};

    // PRIME fetches the current phase; RUN prefetches the phase the next tick will produce.
    assign lut_addr    = (state_reg == RUN) ? phase_sum[PHASE_BITS-1 -: LUT_AW]
                                            : phase_reg[PHASE_BITS-1 -: LUT_AW];
    assign lut_addr_en = ((state_reg == PRIME) && (prime_cnt_reg == '0)) ||
                         ((state_reg == RUN) && (cnt_reg == '0));

    sine_quarter_lut #(
        .PERIOD_MAX (PERIOD_MAX),
        .LUT_AW     (LUT_AW)
    ) u_lut (
        .clk     (clk),
        .addr_en (lut_addr_en),
        .addr    (lut_addr),
        .data    (lut_data)
    );

    // Next-state logic: IDLE consumes config at once, RUN only at the tick.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        prime_cnt_next = '0;
        phase_next     = phase_reg;
        step_next      = step_reg;
        width_next     = width_reg;
        shadow_consume = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next   = '0;
                width_next = '0;
                if (shadow_full_reg) begin
                    shadow_consume = 1'b1;
                    if (shadow_enable_reg) begin
                        step_next  = shadow_step_reg;
                        phase_next = '0;
                        state_next = PRIME;
                    end
                end
            end
            PRIME: begin
                cnt_next       = '0;
                prime_cnt_next = prime_cnt_reg + 1'b1;
                if (prime_cnt_reg == PRIME_LAST) begin
                    prime_cnt_next = '0;
                    width_next     = lut_data;
                    state_next     = RUN;
                end
            end
            RUN: begin
                if (last_cnt) begin
                    cnt_next   = '0;
                    width_next = width_pending_reg;
                    // Phase uses the old step; a new step only affects the following tick.
                    phase_next = phase_sum;
                    if (shadow_full_reg) begin
                        shadow_consume = 1'b1;
                        step_next      = shadow_step_reg;
                        if (!shadow_enable_reg) begin
                            width_next = '0;
                            state_next = IDLE;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers; pwm_out is computed from next-cycle values so it lines up with cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            prime_cnt_reg <= '0;
            phase_reg     <= '0;
            step_reg      <= '0;
            width_reg     <= '0;
            pwm_out_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            prime_cnt_reg <= prime_cnt_next;
            phase_reg     <= phase_next;
            step_reg      <= step_next;
            width_reg     <= width_next;
            pwm_out_reg   <= (state_next == RUN) && (DW'(cnt_next) < width_next);
        end
    end

    // Latch the prefetched width once the LUT latency has elapsed in the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_pending_reg <= '0;
        end else if ((state_reg == RUN) && (cnt_reg == CNT_PENDING)) begin
            width_pending_reg <= lut_data;
        end
    end

    // One-deep config shadow; a word arriving on a tick cycle waits for the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_full_reg   <= 1'b0;
            shadow_enable_reg <= 1'b0;
            shadow_step_reg   <= '0;
        end else if (cfg_xfer) begin
            shadow_full_reg   <= 1'b1;
            shadow_enable_reg <= cfg_enable;
            shadow_step_reg   <= cfg_step;
        end else if (shadow_consume) begin
            shadow_full_reg   <= 1'b0;
        end
    end

    assign cfg_ready  = !shadow_full_reg;
    assign width      = {{(32 - DW){1'b0}}, width_reg};
    assign tick       = tick_now;
    assign phase_wrap = tick_now && phase_carry;
    assign pwm_out    = pwm_out_reg;
    assign busy       = (state_reg != IDLE);

endmodule
